// File: rtl/audio_pwm_out.sv
// rtl/audio_pwm_out.sv - PWM audio output with a one-sample holding buffer
// Define AUDIO_PWM_UNDERRUN_EN to add the saturating underrun_cnt output.
module audio_pwm_out #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic [WIDTH-1:0] sample_in,
    input  logic             sample_valid,
    output logic             sample_ready,
    output logic             pwm_out,
    output logic             period_start
`ifdef AUDIO_PWM_UNDERRUN_EN
    ,
    output logic [7:0]       underrun_cnt
`endif
);

    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_duty;
    logic [WIDTH-1:0] r_buf;
    logic             r_buf_full;
    logic             r_pwm;
    logic             r_period_start;

    logic             w_wrap;
    logic             w_accept;
    logic             w_load;

    assign w_wrap   = ena && (r_cnt == {WIDTH{1'b1}});
    assign w_accept = sample_valid && !r_buf_full;
    assign w_load   = w_wrap && r_buf_full;

    assign sample_ready = !r_buf_full;
    assign pwm_out      = r_pwm;
    assign period_start = r_period_start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt          <= '0;
            r_pwm          <= 1'b0;
            r_period_start <= 1'b0;
        end else if (ena) begin
            r_cnt          <= r_cnt + 1'b1;
            r_pwm          <= (r_cnt < r_duty);
            r_period_start <= w_wrap;
        end else begin
            r_pwm          <= 1'b0;
            r_period_start <= 1'b0;
        end
    end

    // Load and accept are mutually exclusive: accepting needs an empty buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_duty     <= '0;
            r_buf      <= '0;
            r_buf_full <= 1'b0;
        end else if (w_load) begin
            r_duty     <= r_buf;
            r_buf_full <= 1'b0;
        end else if (w_accept) begin
            r_buf      <= sample_in;
            r_buf_full <= 1'b1;
        end
    end

`ifdef AUDIO_PWM_UNDERRUN_EN
    logic [7:0] r_underrun;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_underrun <= 8'd0;
        end else if (w_wrap && !r_buf_full && (r_underrun != 8'hFF)) begin
            r_underrun <= r_underrun + 8'd1;
        end
    end

    assign underrun_cnt = r_underrun;
`endif

endmodule

// File: tb/tb_audio_pwm_out.sv
// tb/tb_audio_pwm_out.sv - scoreboard bench for audio_pwm_out
// Reference model predicts each cycle's outputs; monitor compares on falling edges.
module tb_audio_pwm_out;

    localparam int W = 8;
    localparam int P = 1 << W;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         ena = 1'b0;
    logic [W-1:0] sample_in = '0;
    logic         sample_valid = 1'b0;
    logic         sample_ready;
    logic         pwm_out;
    logic         period_start;
`ifdef AUDIO_PWM_UNDERRUN_EN
    logic [7:0]   underrun_cnt;
`endif

    audio_pwm_out #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .ena          (ena),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .pwm_out      (pwm_out),
        .period_start (period_start)
`ifdef AUDIO_PWM_UNDERRUN_EN
        ,
        .underrun_cnt (underrun_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic pwm;
        logic ps;
        logic ready;
        int   under;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    int   m_cnt, m_duty, m_buf, m_under;
    bit   m_full, m_acc;

    initial begin
        m_cnt = 0; m_duty = 0; m_buf = 0; m_under = 0; m_full = 0; m_acc = 0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_cnt = 0; m_duty = 0; m_buf = 0; m_under = 0; m_full = 0; m_acc = 0;
                exp_q.delete();
            end else begin
                exp_t e;
                bit   full_before;
                full_before = m_full;
                e.pwm = 1'b0;
                e.ps  = 1'b0;
                m_acc = 0;
                if (ena) begin
                    e.pwm = (m_cnt < m_duty);
                    if (m_cnt == P - 1) begin
                        e.ps = 1'b1;
                        if (m_full) begin
                            m_duty = m_buf;
                            m_full = 0;
                        end else if (m_under < 255) begin
                            m_under++;
                        end
                    end
                    m_cnt = (m_cnt + 1) % P;
                end
                if (sample_valid && !full_before) begin
                    m_buf  = sample_in;
                    m_full = 1;
                    m_acc  = 1;
                end
                e.ready = !m_full;
                e.under = m_under;
                exp_q.push_back(e);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst && exp_q.size() > 0) begin
                exp_t e;
                bit   bad;
                e = exp_q.pop_front();
                bad = (pwm_out !== e.pwm) || (period_start !== e.ps) || (sample_ready !== e.ready);
`ifdef AUDIO_PWM_UNDERRUN_EN
                bad = bad || (int'(underrun_cnt) != e.under);
`endif
                n_tests++;
                if (bad) begin
                    n_fail++;
                    $display("FAIL scoreboard t=%0t: got pwm=%b ps=%b ready=%b, want pwm=%b ps=%b ready=%b under=%0d",
                             $time, pwm_out, period_start, sample_ready, e.pwm, e.ps, e.ready, e.under);
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic send(input logic [W-1:0] d);
        int t;
        @(negedge clk);
        sample_in    = d;
        sample_valid = 1'b1;
        t = 0;
        forever begin
            @(negedge clk);
            if (m_acc) break;
            t++;
            if (t >= 2000) begin
                check("send_timeout", t, 0);
                break;
            end
        end
        sample_valid = 1'b0;
    endtask

    task automatic wait_ps(input int max, output int n);
        n = 0;
        forever begin
            @(negedge clk);
            n++;
            if (period_start) break;
            if (n >= max) begin
                check("wait_ps_timeout", n, 0);
                break;
            end
        end
    endtask

    task automatic count_high(input int n, output int h);
        h = 0;
        repeat (n) begin
            @(negedge clk);
            h += int'(pwm_out);
        end
    endtask

    initial begin
        int n, h, ps_cnt;

        repeat (3) @(negedge clk);
        check("reset_pwm", int'(pwm_out), 0);
        check("reset_ps", int'(period_start), 0);
        check("reset_ready", int'(sample_ready), 1);
        rst = 1'b0;
        ena = 1'b1;

        // No samples: duty stays 0, wrap every 256 clocks.
        ps_cnt = 0; h = 0;
        repeat (600) begin
            @(negedge clk);
            ps_cnt += int'(period_start);
            h      += int'(pwm_out);
        end
        check("idle_run_ps_pulses", ps_cnt, 2);
        check("idle_run_pwm_high", h, 0);

        send(8'h40);
        wait_ps(600, n);
        count_high(P, h);
        check("duty_40_high", h, 64);

        send(8'hFF);
        wait_ps(600, n);
        fork
            send(8'h00);
            count_high(P, h);
        join
        check("duty_ff_high", h, 255);
        count_high(P, h);
        check("duty_00_high", h, 0);

        // 0x80 held while buffer is full must wait for the wrap.
        send(8'h11);
        send(8'h80);
        wait_ps(600, n);
        count_high(P, h);
        check("duty_80_high", h, 128);

        n = 0;
        while (m_cnt != 100 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("reach_cnt_100", m_cnt, 100);
        ena = 1'b0;
        count_high(10, h);
        check("ena_low_pwm", h, 0);
        ena = 1'b1;
        repeat (5) @(negedge clk);

        fork
            begin
                repeat (2500) begin
                    @(negedge clk);
                    ena = ($urandom_range(0, 9) != 0);
                end
                ena = 1'b1;
            end
            begin
                repeat (8) begin
                    repeat ($urandom_range(0, 200)) @(negedge clk);
                    send(W'($urandom));
                end
            end
        join
        ena = 1'b1;

        send(8'hC0);
        wait_ps(600, n);
        send(8'h22);
        repeat (10) @(negedge clk);
        check("pre_reset_pwm", int'(pwm_out), 1);
        check("pre_reset_ready", int'(sample_ready), 0);
        #2 rst = 1'b1;
        #1;
        check("async_reset_pwm", int'(pwm_out), 0);
        check("async_reset_ps", int'(period_start), 0);
        check("async_reset_ready", int'(sample_ready), 1);
`ifdef AUDIO_PWM_UNDERRUN_EN
        check("async_reset_under", int'(underrun_cnt), 0);
`endif
        @(negedge clk);
        rst = 1'b0;
        wait_ps(600, n);
        check("first_wrap_after_reset", n, P);
        count_high(P, h);
        check("post_reset_duty_cleared", h, 0);

`ifdef AUDIO_PWM_UNDERRUN_EN
        repeat (300 * P) @(negedge clk);
        check("underrun_saturate", int'(underrun_cnt), 255);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("underrun_reset", int'(underrun_cnt), 0);
        @(negedge clk);
        rst = 1'b0;
`endif

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
